dataflow_invariant_arbiter: RTL
===============================

# dataflow_invariant_arbiter

Shares one stored invariant value among `NUM_REQ` consumer streams. Loads a value once, then serves round-robin "done" tokens from the requesters. Each served token produces one tagged copy of the value on a single registered output channel. A flush handshake returns the block to the load state so the next outer-loop invariant can be captured. It sits between an invariant producer and several loop bodies in the dataflow fabric.

## Interface
Parameters:
- `WIDTH`, 32, data width of the invariant value.
- `NUM_REQ`, 4, number of requester streams; legal range 2..16.
- `IDW`, `$clog2(NUM_REQ)`, derived localparam; width of the requester id.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  invariant value valid.
- `a_ready`  out  1  invariant value accepted.
- `a_data`  in  WIDTH  invariant value.
- `d_valid`  in  NUM_REQ  per-requester done token valid.
- `d_ready`  out  NUM_REQ  per-requester token accepted (one-hot or zero).
- `flush_valid`  in  1  request to discard the stored value.
- `flush_ready`  out  1  flush accepted.
- `o_valid`  out  1  output copy valid.
- `o_ready`  in  1  downstream accepts output.
- `o_data`  out  WIDTH  stored invariant value.
- `o_id`  out  IDW  index of the requester served.
- `served_count`  out  16  grants since the last load; saturates at 0xFFFF.

## Operation
- States: `S_LOAD`, `S_REPEAT`. Any other encoding goes to `S_LOAD`.
- Reset (sampled at an edge with `rst`=1) sets:
  - state `S_LOAD`, stored value 0, rr pointer 0;
  - output register empty, `o_valid`=0, `o_data`=0, `o_id`=0;
  - `served_count`=0.
- Outputs after reset: `a_ready`=1, `d_ready`=0, `flush_ready`=0.
- A reset mid-operation drops any held output and loses the stored value.
- `S_LOAD`:
  - `a_ready`=1; `d_ready` and `flush_ready` are 0.
  - On `a_valid`: capture `a_data`, clear `served_count`, set rr pointer to 0, go to `S_REPEAT`.
- `S_REPEAT`:
  - `a_ready`=0; `a_valid` is ignored.
  - `can_issue` = output register empty OR `o_ready`.
  - Grant goes to the first `d_valid[i]` found scanning from the rr pointer upward, with wrap-around.
  - `d_ready[grant]`=1 only when `can_issue` is 1, `flush_valid` is 0, and some `d_valid` is set.
- On grant to `i`:
  - the output register loads `o_data`=stored value and `o_id`=i, with `o_valid`=1;
  - pointer becomes (i+1) mod `NUM_REQ`;
  - `served_count` increments, saturating.
- When the output handshake fires with no new grant, `o_valid` clears next cycle.
- Flush has priority over tokens:
  - while `flush_valid`=1, no grants are issued;
  - `flush_ready`=1 only when the output register is empty;
  - on the flush handshake, go to `S_LOAD`.
- `o_data`/`o_id` hold stable while `o_valid`=1 and `o_ready`=0.
- `d_ready` never depends on `o_valid` of the same cycle except via `can_issue`. Requesters must not gate `d_valid` on `d_ready`.

## Timing
- Value load: `a` accepted at cycle t gives `S_REPEAT` at t+1, so the earliest `d_ready` is at t+1.
- Token latency: `d` accepted at cycle t gives `o_valid`=1 at t+1.
- Throughput: one token per cycle with `o_ready` held at 1.
- Back-pressure: with `o_ready`=0 and `o_valid`=1, all `d_ready` are 0.
- Flush accepted at t: `a_ready`=1 at t+1.
- If flush arrives while the output register holds data, `flush_ready` rises the cycle after the output handshake.
- Flush and token valid in the same cycle: flush wins and the token waits. It is lost if the requester drops it, which is legal only after `S_LOAD`.

## Structure
- Shared package `dataflow_pkg` holds:
  - the `inv_arb_state_t` enum (`S_LOAD`=2'b00, `S_REPEAT`=2'b01);
  - the `SERVED_CNT_W`=16 constant.
- Sub-module `dataflow_rr_arbiter` (params `NUM_REQ`):
  - owns the rr pointer register;
  - inputs `req`, `advance`, `clear`;
  - outputs a one-hot `grant` and a `grant_id`.
- FSM, value register, output register and counter stay in the top module.

## Test plan
- Reset then load: `a_data`=0xDEADBEEF at cycle 2 → `a_ready` drops at cycle 3; `d_valid`=4'b0001 at cycle 3 → `o_valid`/`o_data`=0xDEADBEEF/`o_id`=0 at cycle 4.
- Round-robin fairness: `d_valid`=4'b1111 held, `o_ready`=1 → `o_id` sequence 0,1,2,3,0 on consecutive cycles; `served_count` reaches 5.
- Back-pressure: `o_ready`=0 for 3 cycles with `d_valid`=4'b0110 → `o_id`=1 held stable and `d_ready`=0 throughout; after release, next `o_id`=2.
- Flush during held output: `o_valid`=1, `o_ready`=0, `flush_valid`=1 → `flush_ready`=0; after the `o_ready` handshake, `flush_ready`=1 the next cycle, then `a_ready`=1; a new `a_data`=0x5 is served as 0x5.
- Ignored load and reset mid-stream: `a_valid` in `S_REPEAT` → stored value unchanged; `rst` asserted while `o_valid`=1 → next cycle `o_valid`=0, `a_ready`=1, `served_count`=0.
- Saturation: force 70000 grants → `served_count`=0xFFFF, no wrap.

Source files
------------

// File: rtl/dataflow_pkg.sv
// Shared types and constants for the dataflow invariant arbiter slice.
package dataflow_pkg;

  typedef enum logic [1:0] {
    S_LOAD   = 2'b00,
    S_REPEAT = 2'b01
  } inv_arb_state_t;

  localparam int unsigned SERVED_CNT_W = 16;

endpackage

// File: rtl/dataflow_invariant_arbiter_if.sv
// Handshake bundle between the invariant producer, the requesters and the output consumer.
interface dataflow_invariant_arbiter_if
  import dataflow_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);

  logic                    a_valid;
  logic                    a_ready;
  logic [WIDTH-1:0]        a_data;
  logic [NUM_REQ-1:0]      d_valid;
  logic [NUM_REQ-1:0]      d_ready;
  logic                    flush_valid;
  logic                    flush_ready;
  logic                    o_valid;
  logic                    o_ready;
  logic [WIDTH-1:0]        o_data;
  logic [IDW-1:0]          o_id;
  logic [SERVED_CNT_W-1:0] served_count;

  // Environment side: producer, requesters, flush source and output consumer.
  modport master (
    output a_valid, a_data, d_valid, flush_valid, o_ready,
    input  a_ready, d_ready, flush_ready, o_valid, o_data, o_id, served_count
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_data, d_valid, flush_valid, o_ready,
    output a_ready, d_ready, flush_ready, o_valid, o_data, o_id, served_count
  );

endinterface

// File: rtl/dataflow_rr_arbiter.sv
// Round-robin arbiter: scans upward from the pointer with wrap-around, pointer moves past
// the winner on advance and returns to 0 on clear.
module dataflow_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic               clear,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  int unsigned    idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req[IDW'(idx)]) begin
        found                = 1'b1;
        grant[IDW'(idx)]     = 1'b1;
        grant_id             = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (advance && found) begin
      ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dataflow_invariant_arbiter.sv
// Holds one loop-invariant value and hands a tagged copy of it to each requester token,
// round-robin, through a single registered output; flush returns to the load state.
module dataflow_invariant_arbiter
  import dataflow_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4
) (
  input logic                   clk,
  input logic                   rst,
  dataflow_invariant_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  inv_arb_state_t          state_q, state_d;
  logic [WIDTH-1:0]        value_q, value_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [IDW-1:0]          out_id_q, out_id_d;
  logic [SERVED_CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               can_issue;
  logic               issue;
  logic               arb_clear;
  logic               a_ready;
  logic               flush_ready;

  dataflow_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.d_valid),
    .advance  (issue),
    .clear    (arb_clear),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    cnt_d       = cnt_q;
    arb_clear   = 1'b0;
    issue       = 1'b0;
    a_ready     = 1'b0;
    flush_ready = 1'b0;
    can_issue   = !out_valid_q || bus.o_ready;

    case (state_q)
      S_LOAD: begin
        a_ready = 1'b1;
        if (bus.a_valid) begin
          value_d   = bus.a_data;
          cnt_d     = '0;
          arb_clear = 1'b1;
          state_d   = S_REPEAT;
        end
      end
      S_REPEAT: begin
        flush_ready = !out_valid_q;
        // A pending flush blocks new grants so the output register can drain.
        issue = can_issue && !bus.flush_valid && (|bus.d_valid);
        if (issue && (cnt_q != {SERVED_CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.flush_valid && flush_ready) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_data_d  = value_q;
      out_id_d    = grant_id;
    end else if (out_valid_q && bus.o_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      value_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.a_ready      = a_ready;
  assign bus.flush_ready  = flush_ready;
  assign bus.d_ready      = issue ? grant : '0;
  assign bus.o_valid      = out_valid_q;
  assign bus.o_data       = out_data_q;
  assign bus.o_id         = out_id_q;
  assign bus.served_count = cnt_q;

endmodule
